// File: rtl/data_mem_pipe.sv
// Single-port word memory with byte enables, fixed read latency and an in-order
// response buffer. Zero-fills the array after reset when INIT_ZERO is set.
// Read data appears on rsp_* in the LAT-th cycle after the accept edge, i.e. the
// handshake can complete on accept edge + LAT.
module data_mem_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LAT       = 2,
  parameter int unsigned RSP_DEPTH = LAT + 2,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned PtrW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(RSP_DEPTH + 1);
  localparam logic [CntW-1:0] RspDepthC = CntW'(RSP_DEPTH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(RSP_DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     init_cnt_q, init_cnt_d;   // MSB set once every word is cleared
  logic                init_done_q, init_done_d;
  logic                req_ready_q, req_ready_d;
  logic [CntW-1:0]     outst_q, outst_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     fill_q, fill_d;
  logic [DATA_W-1:0]   rbuf_q [RSP_DEPTH];

  logic [DATA_W-1:0]   mem [Depth];
  logic [ADDR_W-1:0]   addr;
  logic                req_acc, rd_acc, wr_acc, rsp_pop;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NumBytes-1:0] mem_wbe;
  logic [DATA_W-1:0]   mem_rdata;
  logic                push_vld;
  logic [DATA_W-1:0]   push_dat;

  assign addr      = req_addr[ADDR_W-1:0];
  assign req_acc   = req_valid && req_ready_q;
  assign rd_acc    = req_acc && !req_we;
  assign wr_acc    = req_acc && req_we;
  assign rsp_valid = (fill_q != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_rdata = rbuf_q[rd_ptr_q];
  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign mem_rdata = mem[addr];

  if (ADDR_W < 32) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
  end

  // Write port mux: zero-fill owns the port during INIT, accepted writes in RUN.
  // Gated by rst_n so that holding reset never touches memory contents.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = req_wdata;
    mem_wbe   = req_be;
    if (state_q == StInit) begin
      mem_we    = rst_n && !init_cnt_q[ADDR_W];
      mem_waddr = init_cnt_q[ADDR_W-1:0];
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // Memory array, byte-granular write, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (mem_wbe[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read pipeline: the memory is sampled at the accept edge and reaches the
  // response buffer LAT-1 edges later.
  if (LAT == 1) begin : g_lat1
    assign push_vld = rd_acc;
    assign push_dat = mem_rdata;
  end else begin : g_pipe
    logic              pv_q [LAT-1];
    logic [DATA_W-1:0] pd_q [LAT-1];

    // Shift read data and valid bits towards the response buffer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT - 1; i++) begin
          pv_q[i] <= 1'b0;
          pd_q[i] <= '0;
        end
      end else begin
        pv_q[0] <= rd_acc;
        pd_q[0] <= mem_rdata;
        for (int i = 1; i < LAT - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
          pd_q[i] <= pd_q[i-1];
        end
      end
    end

    assign push_vld = pv_q[LAT-2];
    assign push_dat = pd_q[LAT-2];
  end

  // Next state for controller FSM, outstanding count and response buffer pointers.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == StInit) begin
      if (init_cnt_q[ADDR_W]) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end

    outst_d = outst_q;
    if (rd_acc && !rsp_pop) begin
      outst_d = outst_q + 1'b1;
    end else if (!rd_acc && rsp_pop) begin
      outst_d = outst_q - 1'b1;
    end
    // Registered so a pop in a full cycle only frees a slot from the next cycle.
    req_ready_d = (state_d == StRun) && (outst_d < RspDepthC);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_vld) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    if (rsp_pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    if (push_vld && !rsp_pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push_vld && rsp_pop) begin
      fill_d = fill_q - 1'b1;
    end
  end

  // Control state and response buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_ZERO ? StInit : StRun;
      init_cnt_q  <= '0;
      init_done_q <= !INIT_ZERO;
      req_ready_q <= 1'b0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rbuf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      req_ready_q <= req_ready_d;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      if (push_vld) rbuf_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe: three builds (LAT=2, 1, 4) with ADDR_W=4.
// Stimulus pushes expected read responses; a negedge monitor pops and compares.
module tb_data_mem_pipe;

  localparam int ND = 3;

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          due;
    bit          chk_lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_we    [ND];
  logic [31:0] req_addr  [ND];
  logic [31:0] req_wdata [ND];
  logic [3:0]  req_be    [ND];
  logic        rsp_valid [ND];
  logic        rsp_ready [ND];
  logic [31:0] rsp_rdata [ND];
  logic        init_done [ND];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc;

  data_mem_pipe #(.DATA_W(32), .ADDR_W(4), .LAT(2), .RSP_DEPTH(4), .INIT_ZERO(1'b1)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .init_done(init_done[0])
  );

  data_mem_pipe #(.DATA_W(32), .ADDR_W(4), .LAT(1), .RSP_DEPTH(3), .INIT_ZERO(1'b1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .init_done(init_done[1])
  );

  data_mem_pipe #(.DATA_W(32), .ADDR_W(4), .LAT(4), .RSP_DEPTH(6), .INIT_ZERO(1'b1)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .init_done(init_done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every handshake must match the oldest expectation for that build.
  always @(negedge clk) begin : mon
    int idx;
    for (int d = 0; d < ND; d++) begin
      if (rsp_valid[d] && rsp_ready[d]) begin
        idx = -1;
        foreach (sb_q[i]) if (idx < 0 && sb_q[i].dut == d) idx = i;
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got data %0h, required no response", d,
                   rsp_rdata[d]);
        end else begin
          check($sformatf("rsp_data_dut%0d", d), 64'(rsp_rdata[d]), 64'(sb_q[idx].data));
          if (sb_q[idx].chk_lat)
            check($sformatf("rsp_cycle_dut%0d", d), 64'(cyc), 64'(sb_q[idx].due));
          sb_q.delete(idx);
        end
      end
    end
  end

  // Present one request and leave it asserted until the accept edge.
  task automatic send(input int d, input bit we, input int addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp, input bit chk_lat);
    int budget;
    @(posedge clk); #1;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = 32'(addr);
    req_wdata[d] = wd;
    req_be[d]    = be;
    budget = 50;
    while (!req_ready[d] && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!req_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL req_timeout dut%0d: req_ready 0, required 1 within 50 cycles", d);
    end else if (!we) begin
      sb_q.push_back('{d, exp, cyc + lat_of(d), chk_lat});
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses missing, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // 16 edges of zero-fill, then RUN on edge 17.
  task automatic check_init();
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("init_done_edge16_dut%0d", d), 64'(init_done[d]), 64'd0);
      check($sformatf("req_ready_edge16_dut%0d", d), 64'(req_ready[d]), 64'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("init_done_edge17_dut%0d", d), 64'(init_done[d]), 64'd1);
      check($sformatf("req_ready_edge17_dut%0d", d), 64'(req_ready[d]), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b1;
    end
    #3 rst_n = 1'b0;
    #10;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_req_ready_dut%0d", d), 64'(req_ready[d]), 64'd0);
      check($sformatf("rst_rsp_valid_dut%0d", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("rst_rsp_rdata_dut%0d", d), 64'(rsp_rdata[d]), 64'd0);
      check($sformatf("rst_init_done_dut%0d", d), 64'(init_done[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_init();

    // Zero-filled read, then write-then-read of addr 7 on every latency build.
    send(0, 1'b0, 5, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    idle(0);
    for (int d = 0; d < ND; d++) begin
      send(d, 1'b1, 7, 32'h7700_0000 + 32'(d), 4'hF, 32'h0, 1'b0);
      send(d, 1'b0, 7, 32'h0, 4'h0, 32'h7700_0000 + 32'(d), 1'b1);
      idle(d);
    end
    drain();

    // Byte enables: full write, low-byte write, then a no-op write.
    send(0, 1'b1, 3, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    send(0, 1'b1, 3, 32'h0000_00AA, 4'h1, 32'h0, 1'b0);
    send(0, 1'b0, 3, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b1);
    send(0, 1'b1, 3, 32'h1234_5678, 4'h0, 32'h0, 1'b0);
    send(0, 1'b0, 3, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b1);
    send(0, 1'b1, 3, 32'h0055_0000, 4'h4, 32'h0, 1'b0);
    send(0, 1'b0, 3, 32'h0, 4'h0, 32'hDE55_BEAA, 1'b1);
    idle(0);
    drain();

    // Backpressure: buffer fills to RSP_DEPTH, then drains in order.
    for (int i = 0; i < 4; i++) send(0, 1'b1, 8 + i, 32'hC0DE_0000 + 32'(i), 4'hF, 32'h0, 1'b0);
    idle(0);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'd8;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready[0]) begin
        sb_q.push_back('{0, 32'hC0DE_0000 + 32'(n_acc), 0, 1'b0});
        n_acc++;
      end
      @(posedge clk); #1;
      req_addr[0] = 32'(8 + n_acc);
    end
    req_valid[0] = 1'b0;
    check("bp_accepted", 64'(n_acc), 64'd4);
    check("bp_req_ready_full", 64'(req_ready[0]), 64'd0);
    check("bp_rsp_valid_held", 64'(rsp_valid[0]), 64'd1);
    check("bp_rsp_rdata_held", 64'(rsp_rdata[0]), 64'hC0DE_0000);
    rsp_ready[0] = 1'b1;
    drain();
    @(posedge clk); #1;
    check("bp_req_ready_after", 64'(req_ready[0]), 64'd1);

    // Streaming: 20 back-to-back reads across buffer wrap.
    for (int i = 0; i < 16; i++) send(0, 1'b1, i, 32'hA000_0000 + 32'(i * 257), 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) send(0, 1'b0, i % 16, 32'h0, 4'h0, 32'hA000_0000 + 32'((i % 16) * 257), 1'b1);
    idle(0);
    drain();

    // Reset with three reads held in the buffer.
    rsp_ready[0] = 1'b0;
    for (int i = 1; i <= 3; i++) send(0, 1'b0, i, 32'h0, 4'h0, 32'hA000_0000 + 32'(i * 257), 1'b0);
    idle(0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_rst_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("midrst_req_ready", 64'(req_ready[0]), 64'd0);
    check("midrst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
    check("midrst_init_done", 64'(init_done[0]), 64'd0);
    sb_q.delete();
    rsp_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_init();
    send(0, 1'b0, 0, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    send(0, 1'b0, 15, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    idle(0);
    drain();
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width; depth is 2^ADDR_W words.
REQ-003 SHALL have parameter LAT, default 2, read latency in cycles; legal range is 1..4.
REQ-004 SHALL have parameter RSP_DEPTH, default LAT+2, maximum number of outstanding reads; legal range is LAT+1..8.
REQ-005 SHALL have parameter INIT_ZERO, default 1; when 1, the block zero-fills memory after reset.
REQ-006 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  word address; only bits [ADDR_W-1:0] are used; upper bits are ignored.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte write enables; bit i covers byte i.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response at a rising edge when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; stable while rsp_valid && !rsp_ready.
- init_done  out  1  high once the zero-fill is complete, or immediately after reset when INIT_ZERO=0.

Function
REQ-007 SHALL implement a controller FSM with states INIT and RUN; reset enters INIT when INIT_ZERO=1, otherwise RUN.
REQ-008 In INIT, the FSM SHALL write 0 to one address per cycle, ascending from 0 to 2^ADDR_W-1, then enter RUN on the following edge with init_done=1.
REQ-009 req_ready SHALL be 0 in INIT and SHALL equal (outstanding < RSP_DEPTH) in RUN.
REQ-010 An accepted write SHALL update, at the accept edge, only the bytes whose req_be bit is 1; req_be=0 makes it a no-op write.
REQ-011 An accepted write SHALL produce no response and SHALL NOT change the outstanding count.
REQ-012 An accepted read SHALL sample memory at the accept edge and SHALL present its data on rsp_rdata with rsp_valid=1 starting LAT cycles after the accept edge, provided no older response is still pending.
REQ-013 Requests SHALL complete in acceptance order; a read accepted the cycle after a write to the same address SHALL return the newly written bytes.
REQ-014 Responses SHALL be held in an in-order buffer of RSP_DEPTH entries, so that rsp_ready=0 never drops or overwrites data.
REQ-015 The outstanding count (reads in the pipeline plus reads in the buffer) SHALL be 0..RSP_DEPTH: +1 on read accept, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-016 With outstanding==RSP_DEPTH, req_ready SHALL be 0 for both reads and writes; a same-cycle response pop SHALL NOT raise req_ready combinationally.
REQ-017 When rsp_ready is held at 1, the block SHALL sustain one read accept per cycle, with back-to-back rsp_valid.
REQ-018 The buffer pointers SHALL wrap modulo RSP_DEPTH with no bubble at wrap-around.

Reset
REQ-019 On rst_n=0, the block SHALL asynchronously force req_ready=0, rsp_valid=0, rsp_rdata=0, outstanding=0, empty pipeline and buffer, and init_done=(INIT_ZERO==0).
REQ-020 Reset SHALL NOT initialise memory contents; the zero-fill (REQ-008) is the only clearing mechanism.
REQ-021 Reset asserted mid-INIT or mid-read SHALL discard all in-flight reads, and the INIT sequence SHALL restart from address 0 after release.
REQ-022 Outputs SHALL first change on the first rising edge after rst_n deasserts.

Verification
REQ-023 Bench SHALL cover each scenario below; use ADDR_W=4 and LAT=2 unless a scenario says otherwise.
- INIT_ZERO=1, release reset -> init_done=1 and req_ready=1 after 16 edges + 1; a read of addr 5 returns 0x00000000.
- Write 0xDEADBEEF to addr 3 with be=0xF, then write 0x000000AA with be=0x1 -> a read of addr 3 returns 0xDEADBEAA exactly 2 cycles after accept.
- rsp_ready=0, issue reads continuously -> exactly RSP_DEPTH=4 reads accepted, then req_ready=0; raise rsp_ready -> 4 responses in issue order, then req_ready=1.
- rsp_ready=1, 20 back-to-back reads of addrs 0..15,0..3 -> 20 responses on consecutive cycles with correct data across buffer wrap.
- Assert rst_n=0 with 3 reads outstanding -> rsp_valid=0 immediately; after release, no stale response appears and INIT restarts from addr 0.
- LAT=1 and LAT=4 builds -> first rsp_valid exactly LAT cycles after accept; write to addr 7 followed next cycle by a read of addr 7 returns the new data.
